arcade_input_ctrl: RTL and testbench

Player-input front end for the Time Pilot core. It sits between `hps_io` (the `ps2_key` and joystick words) and the `time_pilot` control inputs. It decodes keyboard make/break events into latched buttons and merges them with both joysticks. It applies the horizontal-orientation remap and suppresses opposing directions. It also generates a timed coin pulse, with lockout, from start presses.

---
 rtl/arcade_input_pkg.sv | 45 ++++
 rtl/arcade_coin_pulse.sv | 90 +++++++++
 rtl/arcade_input_ctrl.sv | 140 ++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the Time Pilot player-input front end.
//   - PS/2 scan codes recognised by the keyboard decoder
//   - bit positions inside the merged joystick word
//   - coin FSM state type and counter width
package arcade_input_pkg;

    // Arrow keys match on the low 8 bits only; the E0 prefix is ignored for them.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Full 9-bit codes {ext, scan}; right ctrl (0x114) deliberately does not match.
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_CTRL  = 9'h014;
    localparam logic [8:0] SC_F1    = 9'h005;
    localparam logic [8:0] SC_F2    = 9'h006;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;

    localparam int unsigned CNT_W = 24;

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic fire;
        logic start1;
        logic start2;
    } btn_t;

endpackage

// File: rtl/arcade_coin_pulse.sv
// Coin pulse generator: a rising edge on trig (while idle) produces a coin
// pulse of exactly COIN_PULSE cycles followed by a COIN_GAP-cycle lockout.
// Edges arriving during the pulse or lockout are dropped.
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset
//   trig     in  start level (edge-detected internally)
//   coin     out registered coin pulse
module arcade_coin_pulse #(
    parameter int unsigned COIN_PULSE = 1_200_000,
    parameter int unsigned COIN_GAP   = 2_400_000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic trig,
    output logic coin
);
    import arcade_input_pkg::*;

    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GapLoad   = (COIN_GAP == 0) ? '0 : CNT_W'(COIN_GAP - 1);

    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic             coin_q, coin_d;
    logic             trig_q;
    logic             rise;

    // Edge history tracks trig in every state, so a start held through the
    // lockout never produces an edge when the FSM returns to idle.
    assign rise    = trig & ~trig_q;
    assign cnt_dec = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPulse;
                    cnt_d   = PulseLoad;
                    coin_d  = 1'b1;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    coin_d = 1'b0;
                    if (COIN_GAP == 0) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StGap;
                        cnt_d   = GapLoad;
                    end
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            trig_q  <= trig;
        end
    end

    assign coin = coin_q;

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input front end for the Time Pilot core. Decodes PS/2 make/break
// events into latched buttons, merges them with the joysticks, applies the
// horizontal-orientation remap and opposing-direction suppression, and
// generates a timed coin pulse from start presses.
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset
//   ps2_key  in  [64] event toggle, [23:8] prefixes, [7:0] scan code
//   joy      in  OR of both joysticks (right,left,down,up,fire,start1,start2)
//   rotate   in  1 = horizontal orientation remap
//   up/down/left/right/fire/start1/start2/coin1  out  registered, active-high
module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE = 1_200_000,
    parameter int unsigned COIN_GAP   = 2_400_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1
);
    import arcade_input_pkg::*;

    logic       tog_q;
    logic       armed_q;
    logic       ps2_event;
    logic       pressed;
    logic       ext;
    logic [8:0] code;
    btn_t       kb_q, kb_d;
    btn_t       raw;
    btn_t       out_q, out_d;
    logic       rot_up, rot_down, rot_left, rot_right;
    logic       unused_joy;

    assign unused_joy = ^joy[15:7];

    // armed_q masks the first cycle after reset so a stale toggle bit is
    // absorbed into tog_q rather than decoded as an event.
    assign ps2_event = armed_q & (ps2_key[64] != tog_q);

    assign pressed = ps2_key[15:8] != 8'hF0;
    assign ext     = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    // PRNSCR/PAUSE sequences collapse to code 0, which matches nothing.
    assign code    = (ps2_key[63:24] != '0) ? 9'h000 : {ext, ps2_key[7:0]};

    always_comb begin
        kb_d = kb_q;
        if (ps2_event) begin
            if (code[7:0] == SC_UP) begin
                kb_d.up = pressed;
            end else if (code[7:0] == SC_DOWN) begin
                kb_d.down = pressed;
            end else if (code[7:0] == SC_LEFT) begin
                kb_d.left = pressed;
            end else if (code[7:0] == SC_RIGHT) begin
                kb_d.right = pressed;
            end else if (code == SC_SPACE || code == SC_CTRL) begin
                kb_d.fire = pressed;
            end else if (code == SC_F1) begin
                kb_d.start1 = pressed;
            end else if (code == SC_F2) begin
                kb_d.start2 = pressed;
            end
        end
    end

    always_comb begin
        raw.up     = kb_q.up     | joy[JOY_UP];
        raw.down   = kb_q.down   | joy[JOY_DOWN];
        raw.left   = kb_q.left   | joy[JOY_LEFT];
        raw.right  = kb_q.right  | joy[JOY_RIGHT];
        raw.fire   = kb_q.fire   | joy[JOY_FIRE];
        raw.start1 = kb_q.start1 | joy[JOY_START1];
        raw.start2 = kb_q.start2 | joy[JOY_START2];

        if (rotate) begin
            rot_up    = raw.left;
            rot_down  = raw.right;
            rot_left  = raw.down;
            rot_right = raw.up;
        end else begin
            rot_up    = raw.up;
            rot_down  = raw.down;
            rot_left  = raw.left;
            rot_right = raw.right;
        end

        // Opposing directions cancel after the remap.
        out_d.up     = rot_up & ~rot_down;
        out_d.down   = rot_down & ~rot_up;
        out_d.left   = rot_left & ~rot_right;
        out_d.right  = rot_right & ~rot_left;
        out_d.fire   = raw.fire;
        out_d.start1 = raw.start1;
        out_d.start2 = raw.start2;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            kb_q    <= '0;
            out_q   <= '0;
        end else begin
            tog_q   <= ps2_key[64];
            armed_q <= 1'b1;
            kb_q    <= kb_d;
            out_q   <= out_d;
        end
    end

    // Triggered from the next-state start bits so coin1 rises on the same
    // edge as the start output.
    arcade_coin_pulse #(
        .COIN_PULSE (COIN_PULSE),
        .COIN_GAP   (COIN_GAP)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .trig    (out_d.start1 | out_d.start2),
        .coin    (coin1)
    );

    assign up     = out_q.up;
    assign down   = out_q.down;
    assign left   = out_q.left;
    assign right  = out_q.right;
    assign fire   = out_q.fire;
    assign start1 = out_q.start1;
    assign start2 = out_q.start2;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic [15:0] joy;
    logic        rotate;
    logic        up, down, left, right, fire, start1, start2, coin1;

    int   n_cmp = 0;
    int   n_err = 0;
    logic tog;

    arcade_input_ctrl #(
        .COIN_PULSE (4),
        .COIN_GAP   (8)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .joy     (joy),
        .rotate  (rotate),
        .up      (up),
        .down    (down),
        .left    (left),
        .right   (right),
        .fire    (fire),
        .start1  (start1),
        .start2  (start2),
        .coin1   (coin1)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic [7:0] pre2, input logic [7:0] pre1,
                            input logic [7:0] sc, input logic [39:0] hi);
        tog     = ~tog;
        ps2_key = {tog, hi, pre2, pre1, sc};
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tog     = 1'b1;
        ps2_key = {1'b1, 40'h0, 8'h00, 8'h00, 8'h75};
        joy     = 16'h0000;
        rotate  = 1'b0;
        #12;
        n_cmp++;
        if ({up, down, left, right, fire, start1, start2, coin1} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {up, down, left, right, fire, start1, start2, coin1});
        end
        tick;
        reset_n = 1'b1;
        repeat (3) tick;
        n_cmp++;
        if (up !== 1'b0) begin
            n_err++;
            $display("FAIL no_spurious_up: got %b want 0", up);
        end
    endtask

    task automatic test_ps2_make;
        send_key(8'h00, 8'h00, 8'h75, 40'h0);
        tick;
        n_cmp++;
        if (up !== 1'b0) begin
            n_err++;
            $display("FAIL make_latency_1edge: got %b want 0", up);
        end
        tick;
        n_cmp++;
        if (up !== 1'b1) begin
            n_err++;
            $display("FAIL make_up_2edges: got %b want 1", up);
        end
    endtask

    task automatic test_ps2_break;
        send_key(8'hE0, 8'hF0, 8'h75, 40'h0);
        tick; tick;
        n_cmp++;
        if (up !== 1'b0) begin
            n_err++;
            $display("FAIL break_up: got %b want 0", up);
        end
        send_key(8'h00, 8'h00, 8'h75, 40'h0);
        tick; tick;
        n_cmp++;
        if (up !== 1'b1) begin
            n_err++;
            $display("FAIL remake_up: got %b want 1", up);
        end
        // Break of 0x75 carried with nonzero upper bits must be ignored.
        send_key(8'h00, 8'hF0, 8'h75, 40'h00_0000_0100);
        tick; tick;
        n_cmp++;
        if (up !== 1'b1) begin
            n_err++;
            $display("FAIL prnscr_ignored: got %b want 1", up);
        end
        send_key(8'h00, 8'hF0, 8'h75, 40'h0);
        tick; tick;
        n_cmp++;
        if (up !== 1'b0) begin
            n_err++;
            $display("FAIL break_up_again: got %b want 0", up);
        end
        send_key(8'h00, 8'h00, 8'h29, 40'h0);
        tick; tick;
        n_cmp++;
        if (fire !== 1'b1) begin
            n_err++;
            $display("FAIL space_fire: got %b want 1", fire);
        end
        // Ctrl break shares the fire latch with space: last event wins.
        send_key(8'h00, 8'hF0, 8'h14, 40'h0);
        tick; tick;
        n_cmp++;
        if (fire !== 1'b0) begin
            n_err++;
            $display("FAIL ctrl_break_fire: got %b want 0", fire);
        end
        // Right ctrl (E0 14) is a different code.
        send_key(8'h00, 8'hE0, 8'h14, 40'h0);
        tick; tick;
        n_cmp++;
        if (fire !== 1'b0) begin
            n_err++;
            $display("FAIL rctrl_no_fire: got %b want 0", fire);
        end
        send_key(8'h00, 8'hE0, 8'h6B, 40'h0);
        tick; tick;
        n_cmp++;
        if ({up, down, left, right} !== 4'b0010) begin
            n_err++;
            $display("FAIL ext_left_make: got %b want 0010", {up, down, left, right});
        end
        send_key(8'hE0, 8'hF0, 8'h6B, 40'h0);
        tick; tick;
        n_cmp++;
        if (left !== 1'b0) begin
            n_err++;
            $display("FAIL ext_left_break: got %b want 0", left);
        end
    endtask

    task automatic test_rotate;
        logic [15:0] joy_v [8];
        logic        rot_v [8];
        logic [3:0]  exp_v [8];
        joy_v = '{16'h0008, 16'h0001, 16'h0002, 16'h0004,
                  16'h000C, 16'h0003, 16'h0009, 16'h0003};
        rot_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_v = '{4'b0001, 4'b0100, 4'b1000, 4'b0010,
                  4'b0000, 4'b0000, 4'b1001, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            joy    = joy_v[i];
            rotate = rot_v[i];
            tick;
            n_cmp++;
            if ({up, down, left, right} !== exp_v[i]) begin
                n_err++;
                $display("FAIL rotate_vec%0d: got udlr=%b want %b", i,
                         {up, down, left, right}, exp_v[i]);
            end
        end
        rotate = 1'b0;
        joy    = 16'h0010;
        tick;
        n_cmp++;
        if (fire !== 1'b1) begin
            n_err++;
            $display("FAIL joy_fire: got %b want 1", fire);
        end
        joy = 16'h0000;
        tick;
    endtask

    task automatic test_coin;
        logic seen;
        int   high;
        repeat (2) tick;
        joy = 16'h0020;
        tick; // E0
        n_cmp++;
        if ({start1, coin1} !== 2'b11) begin
            n_err++;
            $display("FAIL coin_rise_with_start: got start1,coin1=%b want 11", {start1, coin1});
        end
        joy = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            tick;
            n_cmp++;
            if (coin1 !== 1'b1) begin
                n_err++;
                $display("FAIL coin_high_E%0d: got %b want 1", i, coin1);
            end
        end
        tick; // E4
        n_cmp++;
        if (coin1 !== 1'b0) begin
            n_err++;
            $display("FAIL coin_low_E4: got %b want 0", coin1);
        end
        tick; // E5
        joy = 16'h0020;
        tick; // E6
        n_cmp++;
        if ({start1, coin1} !== 2'b10) begin
            n_err++;
            $display("FAIL lockout_press: got start1,coin1=%b want 10", {start1, coin1});
        end
        joy  = 16'h0000;
        seen = 1'b0;
        repeat (6) begin
            tick;
            seen = seen | coin1;
        end // E12
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL lockout_no_coin: got %b want 0", seen);
        end
        tick; // E13
        joy = 16'h0020;
        tick; // E14
        n_cmp++;
        if (coin1 !== 1'b1) begin
            n_err++;
            $display("FAIL second_coin: got %b want 1", coin1);
        end
        joy  = 16'h0000;
        high = 1;
        repeat (12) begin
            tick;
            if (coin1 === 1'b1) high++;
        end
        n_cmp++;
        if (high != 4) begin
            n_err++;
            $display("FAIL second_coin_width: got %0d want 4", high);
        end
        repeat (2) tick;
    endtask

    task automatic test_simultaneous;
        int   rises;
        int   high;
        logic prev;
        repeat (3) tick;
        send_key(8'h00, 8'h00, 8'h05, 40'h0);
        joy   = 16'h0040;
        rises = 0;
        high  = 0;
        prev  = 1'b0;
        repeat (20) begin
            tick;
            if (coin1 === 1'b1 && prev !== 1'b1) rises++;
            if (coin1 === 1'b1) high++;
            prev = coin1;
        end
        n_cmp++;
        if (rises != 1) begin
            n_err++;
            $display("FAIL simul_one_coin: got %0d rises want 1", rises);
        end
        n_cmp++;
        if (high != 4) begin
            n_err++;
            $display("FAIL simul_coin_width: got %0d want 4", high);
        end
        n_cmp++;
        if ({start1, start2} !== 2'b11) begin
            n_err++;
            $display("FAIL simul_starts: got %b want 11", {start1, start2});
        end
        joy = 16'h0000;
        send_key(8'h00, 8'hF0, 8'h05, 40'h0);
        repeat (16) tick;
    endtask

    task automatic test_reset_pulse;
        int   rises;
        int   high;
        logic prev;
        joy = 16'h0020;
        tick; // E0
        n_cmp++;
        if (coin1 !== 1'b1) begin
            n_err++;
            $display("FAIL rp_coin_start: got %b want 1", coin1);
        end
        tick;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({start1, coin1} !== 2'b00) begin
            n_err++;
            $display("FAIL rp_async_drop: got start1,coin1=%b want 00", {start1, coin1});
        end
        #20;
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        tick;
        n_cmp++;
        if ({start1, coin1} !== 2'b11) begin
            n_err++;
            $display("FAIL rp_held_coin: got start1,coin1=%b want 11", {start1, coin1});
        end
        rises = 1;
        high  = 1;
        prev  = 1'b1;
        repeat (25) begin
            tick;
            if (coin1 === 1'b1 && prev !== 1'b1) rises++;
            if (coin1 === 1'b1) high++;
            prev = coin1;
        end
        n_cmp++;
        if (rises != 1 || high != 4) begin
            n_err++;
            $display("FAIL rp_single_coin: got rises=%0d high=%0d want 1 and 4", rises, high);
        end
        joy = 16'h0000;
        repeat (2) tick;
    endtask

    initial begin
        test_reset;
        test_ps2_make;
        test_ps2_break;
        test_rotate;
        test_coin;
        test_simultaneous;
        test_reset_pulse;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
